// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI flash responder: opcodes, FSM states
// and the number of address bytes in a read command.
package spi_flash_pkg;

    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam logic [7:0] OP_RDID = 8'h9F;

    localparam int unsigned ADDR_BYTES = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_READ,
        ST_STAT,
        ST_ID,
        ST_IGNORE
    } state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizers for the SPI pins plus SCK edge pulses.
// Ports: clk, rst (sync, active high), ss/sck/mosi (async pins),
//        ss_sync/mosi_sync (synchronized), sck_rise/sck_fall (1-clk pulses).
module spi_pin_sync (
    input  logic clk,
    input  logic rst,
    input  logic ss,
    input  logic sck,
    input  logic mosi,
    output logic ss_sync,
    output logic mosi_sync,
    output logic sck_rise,
    output logic sck_fall
);

    logic [1:0] ss_ff;
    logic [1:0] sck_ff;
    logic [1:0] mosi_ff;
    logic       sck_q;

    // ss resets to "selected" so a chip select that is already low when
    // reset drops is never mistaken for a fresh deselect/select cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ss_ff   <= 2'b00;
            sck_ff  <= 2'b00;
            mosi_ff <= 2'b00;
            sck_q   <= 1'b0;
        end else begin
            ss_ff   <= {ss_ff[0], ss};
            sck_ff  <= {sck_ff[0], sck};
            mosi_ff <= {mosi_ff[0], mosi};
            sck_q   <= sck_ff[1];
        end
    end

    assign ss_sync   = ss_ff[1];
    assign mosi_sync = mosi_ff[1];
    assign sck_rise  = sck_ff[1] & ~sck_q;
    assign sck_fall  = ~sck_ff[1] & sck_q;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 responder emulating a minimal serial flash (READ, RDSR, RDID).
// Ports: clk, rst, spi_ss/spi_sck/spi_mosi in, spi_miso/spi_miso_oe out,
//        mem_addr/mem_rd/mem_data sync memory port, cmd_valid/cmd_byte, busy.
// Build option: SPI_FLASH_RESP_JEDEC_ID_EN enables opcode 0x9F (JEDEC ID).
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int unsigned ADDR_W     = 8,
    parameter logic [23:0] JEDEC_ID   = 24'hEF4014,
    parameter logic [7:0]  STATUS_VAL = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_ss,
    input  logic              spi_sck,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_data,
    output logic              cmd_valid,
    output logic [7:0]        cmd_byte,
    output logic              busy
);

    logic ss_sync;
    logic mosi_sync;
    logic sck_rise;
    logic sck_fall;

    spi_pin_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .ss        (spi_ss),
        .sck       (spi_sck),
        .mosi      (spi_mosi),
        .ss_sync   (ss_sync),
        .mosi_sync (mosi_sync),
        .sck_rise  (sck_rise),
        .sck_fall  (sck_fall)
    );

    state_t            state;
    logic [2:0]        bit_cnt;
    logic [2:0]        tx_cnt;
    logic [1:0]        byte_cnt;
    logic [6:0]        rx_sr;
    logic [7:0]        tx_sr;
    logic [7:0]        tx_hold;
    logic [ADDR_W-1:0] addr;
    logic              rd_q;
    logic              armed;

    logic [7:0]        rx_next;
    logic [ADDR_W-1:0] addr_next;
    logic [7:0]        tx_byte;

    assign rx_next   = {rx_sr, mosi_sync};
    assign addr_next = {addr[ADDR_W-2:0], mosi_sync};

`ifdef SPI_FLASH_RESP_JEDEC_ID_EN
    logic [7:0] id_byte;

    always_comb begin
        case (byte_cnt)
            2'd0:    id_byte = JEDEC_ID[23:16];
            2'd1:    id_byte = JEDEC_ID[15:8];
            2'd2:    id_byte = JEDEC_ID[7:0];
            default: id_byte = 8'h00;
        endcase
    end
`else
    logic unused_jedec;
    assign unused_jedec = ^{JEDEC_ID, OP_RDID};
`endif

    // Byte loaded into the TX shifter at the first fall of each byte.
    always_comb begin
        tx_byte = 8'h00;
        case (state)
            ST_READ: tx_byte = tx_hold;
            ST_STAT: tx_byte = STATUS_VAL;
`ifdef SPI_FLASH_RESP_JEDEC_ID_EN
            ST_ID:   tx_byte = id_byte;
`endif
            default: tx_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            bit_cnt     <= 3'd0;
            tx_cnt      <= 3'd0;
            byte_cnt    <= 2'd0;
            rx_sr       <= 7'd0;
            tx_sr       <= 8'h00;
            tx_hold     <= 8'h00;
            addr        <= '0;
            rd_q        <= 1'b0;
            armed       <= 1'b0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            mem_addr    <= '0;
            mem_rd      <= 1'b0;
            cmd_valid   <= 1'b0;
            cmd_byte    <= 8'h00;
            busy        <= 1'b0;
        end else begin
            mem_rd    <= 1'b0;
            cmd_valid <= 1'b0;
            // Memory answers one clk after mem_rd; capture on the next.
            rd_q      <= mem_rd;
            if (rd_q) tx_hold <= mem_data;

            if (ss_sync) begin
                state       <= ST_IDLE;
                armed       <= 1'b1;
                busy        <= 1'b0;
                spi_miso    <= 1'b0;
                spi_miso_oe <= 1'b0;
                bit_cnt     <= 3'd0;
                tx_cnt      <= 3'd0;
                byte_cnt    <= 2'd0;
            end else begin
                if (sck_rise && state != ST_IDLE) begin
                    bit_cnt <= bit_cnt + 3'd1;
                    rx_sr   <= rx_next[6:0];
                end
                case (state)
                    ST_IDLE: begin
                        // Only a select seen after a deselect starts a command.
                        if (armed) begin
                            state <= ST_CMD;
                            busy  <= 1'b1;
                            armed <= 1'b0;
                        end
                    end
                    ST_CMD: begin
                        if (sck_rise && bit_cnt == 3'd7) begin
                            cmd_valid <= 1'b1;
                            cmd_byte  <= rx_next;
                            tx_cnt    <= 3'd0;
                            byte_cnt  <= 2'd0;
                            case (rx_next)
                                OP_READ: state <= ST_ADDR;
                                OP_RDSR: begin
                                    state       <= ST_STAT;
                                    spi_miso_oe <= 1'b1;
                                end
`ifdef SPI_FLASH_RESP_JEDEC_ID_EN
                                OP_RDID: begin
                                    state       <= ST_ID;
                                    spi_miso_oe <= 1'b1;
                                end
`endif
                                default: state <= ST_IGNORE;
                            endcase
                        end
                    end
                    ST_ADDR: begin
                        if (sck_rise) begin
                            addr <= addr_next;
                            if (bit_cnt == 3'd7) begin
                                byte_cnt <= byte_cnt + 2'd1;
                                if (byte_cnt == 2'(ADDR_BYTES - 1)) begin
                                    mem_rd      <= 1'b1;
                                    mem_addr    <= addr_next;
                                    state       <= ST_READ;
                                    spi_miso_oe <= 1'b1;
                                    tx_cnt      <= 3'd0;
                                    byte_cnt    <= 2'd0;
                                end
                            end
                        end
                    end
                    ST_READ, ST_STAT, ST_ID: begin
                        if (sck_fall) begin
                            tx_cnt <= tx_cnt + 3'd1;
                            if (tx_cnt == 3'd0) begin
                                spi_miso <= tx_byte[7];
                                tx_sr    <= {tx_byte[6:0], 1'b0};
                                // Prefetch the next byte while this one shifts.
                                if (state == ST_READ) begin
                                    mem_rd   <= 1'b1;
                                    mem_addr <= addr + 1'b1;
                                    addr     <= addr + 1'b1;
                                end
                                if (state == ST_ID && byte_cnt != 2'd3)
                                    byte_cnt <= byte_cnt + 2'd1;
                            end else begin
                                spi_miso <= tx_sr[7];
                                tx_sr    <= {tx_sr[6:0], 1'b0};
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Self-checking bench for spi_flash_responder: directed SPI transactions,
// a byte-level flash model and per-bit MISO/OE comparison.
module tb_spi_flash_responder;

    localparam int HALF = 6;

`ifdef SPI_FLASH_RESP_JEDEC_ID_EN
    localparam bit ID_EN = 1'b1;
`else
    localparam bit ID_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       spi_ss;
    logic       spi_sck;
    logic       spi_mosi;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic [7:0] mem_addr;
    logic       mem_rd;
    logic [7:0] mem_data = 8'h00;
    logic       cmd_valid;
    logic [7:0] cmd_byte;
    logic       busy;

    spi_flash_responder dut (
        .clk         (clk),
        .rst         (rst),
        .spi_ss      (spi_ss),
        .spi_sck     (spi_sck),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .cmd_valid   (cmd_valid),
        .cmd_byte    (cmd_byte),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Synchronous memory image: mem[a] = a ^ 0x5A.
    always @(posedge clk) if (mem_rd) mem_data <= mem_addr ^ 8'h5A;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Flash model: what each data byte must be for a given command.
    function automatic logic model_oe(input logic [7:0] cmd);
        return cmd == 8'h03 || cmd == 8'h05 || (ID_EN && cmd == 8'h9F);
    endfunction

    function automatic logic [7:0] model_byte(input logic [7:0] cmd,
                                              input logic [23:0] a,
                                              input int k);
        logic [7:0]  ea;
        logic [23:0] id;
        id = 24'hEF4014;
        ea = a[7:0] + 8'(k);
        case (cmd)
            8'h03:   return ea ^ 8'h5A;
            8'h9F:   return (k < 3) ? id[23 - 8*k -: 8] : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    typedef struct packed { logic oe; logic chk; logic b; } exp_t;
    exp_t       exp_q[$];
    logic [7:0] rx_sh = 8'h00;
    logic [7:0] rx_got[$];

    // Compare process: every host sampling edge checks OE and data bit.
    always @(posedge spi_sck) begin
        exp_t e;
        rx_sh = {rx_sh[6:0], spi_miso};
        if (exp_q.size() == 0) begin
            chk("exp_underflow", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk("miso_oe", spi_miso_oe, e.oe);
            if (e.chk) chk("miso_bit", spi_miso, e.b);
        end
    end

    int   cv_cnt  = 0;
    logic [7:0] cv_last = 8'h00;
    logic oe_seen = 1'b0;

    always @(negedge clk) begin
        if (cmd_valid) begin
            cv_cnt++;
            cv_last = cmd_byte;
        end
        if (spi_miso_oe) oe_seen = 1'b1;
    end

    task automatic clk_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sck_bit(input logic mo);
        spi_mosi = mo;
        clk_wait(HALF);
        spi_sck = 1'b1;
        clk_wait(HALF);
        spi_sck = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        exp_t e;
        e = '0;
        for (int i = n - 1; i >= 0; i--) begin
            exp_q.push_back(e);
            sck_bit(v[i]);
        end
    endtask

    task automatic recv_bytes(input logic [7:0] cmd, input logic [23:0] a,
                              input int n);
        exp_t       e;
        logic [7:0] eb;
        for (int k = 0; k < n; k++) begin
            eb = model_byte(cmd, a, k);
            for (int i = 7; i >= 0; i--) begin
                e.oe  = model_oe(cmd);
                e.chk = model_oe(cmd);
                e.b   = eb[i];
                exp_q.push_back(e);
                sck_bit(1'($urandom_range(0, 1)));
            end
            rx_got.push_back(rx_sh);
        end
    endtask

    task automatic xfer(input logic [7:0] cmd, input logic [23:0] a,
                        input int n);
        rx_got.delete();
        spi_ss = 1'b0;
        clk_wait(HALF);
        send_bits({24'd0, cmd}, 8);
        if (cmd == 8'h03) send_bits({8'd0, a}, 24);
        recv_bytes(cmd, a, n);
        clk_wait(HALF);
        spi_ss = 1'b1;
        clk_wait(8);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cv0;
        rst = 1'b1; spi_ss = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
        clk_wait(4);
        chk("rst_miso",   spi_miso,    0);
        chk("rst_oe",     spi_miso_oe, 0);
        chk("rst_mem_rd", mem_rd,      0);
        chk("rst_maddr",  mem_addr,    0);
        chk("rst_cv",     cmd_valid,   0);
        chk("rst_cbyte",  cmd_byte,    0);
        chk("rst_busy",   busy,        0);
        rst = 1'b0;
        clk_wait(8);

        cv0 = cv_cnt;
        xfer(8'h03, 24'h000010, 3);
        chk("rd10_b0", rx_got[0], 8'h4A);
        chk("rd10_b1", rx_got[1], 8'h4B);
        chk("rd10_b2", rx_got[2], 8'h48);
        chk("rd10_cv_cnt", cv_cnt - cv0, 1);
        chk("rd10_cmd", cv_last, 8'h03);

        xfer(8'h03, 24'h0000FE, 4);
        chk("wrap_b0", rx_got[0], 8'hA4);
        chk("wrap_b1", rx_got[1], 8'hA5);
        chk("wrap_b2", rx_got[2], 8'h5A);
        chk("wrap_b3", rx_got[3], 8'h5B);

        xfer(8'h05, 24'h0, 2);
        chk("stat_b0", rx_got[0], 8'h00);
        chk("stat_b1", rx_got[1], 8'h00);
        chk("stat_cmd", cv_last, 8'h05);

        oe_seen = 1'b0;
        xfer(8'h9F, 24'h0, 4);
        chk("id_cmd", cv_last, 8'h9F);
        if (ID_EN) begin
            chk("id_b0", rx_got[0], 8'hEF);
            chk("id_b1", rx_got[1], 8'h40);
            chk("id_b2", rx_got[2], 8'h14);
            chk("id_b3", rx_got[3], 8'h00);
        end else begin
            chk("id_oe_never", oe_seen, 1'b0);
        end

        oe_seen = 1'b0;
        cv0 = cv_cnt;
        xfer(8'hAB, 24'h0, 1);
        chk("ign_cv_cnt", cv_cnt - cv0, 1);
        chk("ign_cmd", cv_last, 8'hAB);
        chk("ign_oe_never", oe_seen, 1'b0);

        // Abort after 12 address bits.
        spi_ss = 1'b0;
        clk_wait(HALF);
        send_bits(32'h03, 8);
        send_bits(32'hABC, 12);
        clk_wait(2);
        chk("abort_busy_before", busy, 1'b1);
        spi_ss = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("abort_busy", busy, 1'b0);
        chk("abort_oe", spi_miso_oe, 1'b0);
        clk_wait(8);
        xfer(8'h03, 24'h000001, 1);
        chk("after_abort_b0", rx_got[0], 8'h5B);

        // Reset in the middle of a READ data byte.
        rx_got.delete();
        spi_ss = 1'b0;
        clk_wait(HALF);
        send_bits(32'h03, 8);
        send_bits(32'h000020, 24);
        recv_bytes(8'h03, 24'h000020, 1);
        chk("pre_rst_b0", rx_got[0], 8'h7A);
        begin
            exp_t e;
            logic [7:0] eb;
            eb = model_byte(8'h03, 24'h000020, 1);
            for (int i = 7; i >= 5; i--) begin
                e.oe = 1'b1; e.chk = 1'b1; e.b = eb[i];
                exp_q.push_back(e);
                sck_bit(1'b1);
            end
        end
        chk("pre_rst_busy", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_miso",   spi_miso,    0);
        chk("mid_rst_oe",     spi_miso_oe, 0);
        chk("mid_rst_mem_rd", mem_rd,      0);
        chk("mid_rst_maddr",  mem_addr,    0);
        chk("mid_rst_cv",     cmd_valid,   0);
        chk("mid_rst_cbyte",  cmd_byte,    0);
        chk("mid_rst_busy",   busy,        0);
        rst = 1'b0;
        oe_seen = 1'b0;
        cv0 = cv_cnt;
        begin
            exp_t e;
            e.oe = 1'b0; e.chk = 1'b1; e.b = 1'b0;
            for (int i = 0; i < 16; i++) begin
                exp_q.push_back(e);
                sck_bit(1'b1);
            end
        end
        chk("post_rst_oe", oe_seen, 1'b0);
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_cv", cv_cnt - cv0, 0);
        spi_ss = 1'b1;
        clk_wait(8);
        xfer(8'h03, 24'h000000, 1);
        chk("fresh_b0", rx_got[0], 8'h5A);
        chk("exp_q_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
